// File: rtl/axi4_mmio_master.sv
// Single-outstanding MMIO initiator: one command becomes one single-beat 32-bit AXI4 read or write.
// cmd->rsp takes 3 cycles when the slave is ready (1 cycle for a misaligned command); AXI readies stretch their state.
module axi4_mmio_master #(
  parameter logic [3:0] ID = 4'h0
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [30:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_write,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        aw_valid,
  input  logic        aw_ready,
  output logic [3:0]  aw_id,
  output logic [30:0] aw_addr,
  output logic [7:0]  aw_len,
  output logic [2:0]  aw_size,
  output logic [1:0]  aw_burst,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic [7:0]  w_strb,
  output logic        w_last,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [3:0]  b_id,
  input  logic [1:0]  b_resp,
  output logic        ar_valid,
  input  logic        ar_ready,
  output logic [3:0]  ar_id,
  output logic [30:0] ar_addr,
  output logic [7:0]  ar_len,
  output logic [2:0]  ar_size,
  output logic [1:0]  ar_burst,
  input  logic        r_valid,
  output logic        r_ready,
  input  logic [3:0]  r_id,
  input  logic [31:0] r_data,
  input  logic [1:0]  r_resp,
  input  logic        r_last
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RESP} state_t;

  state_t      state_q;
  logic        cmd_ready_q, aw_valid_q, w_valid_q, aw_done_q, w_done_q;
  logic        b_ready_q, ar_valid_q, r_ready_q, rsp_valid_q, rsp_write_q, first_beat_q;
  logic [30:0] addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  resp_q, rerr_q;
  logic        aw_done_d, w_done_d;
  logic [1:0]  rerr_d;

  // DECERR from any beat dominates; every other anomaly collapses to SLVERR.
  always_comb begin
    aw_done_d = aw_done_q | (aw_valid_q & aw_ready);
    w_done_d  = w_done_q | (w_valid_q & w_ready);
    rerr_d    = rerr_q;
    if (r_resp == 2'b11) begin
      rerr_d = 2'b11;
    end else if (((r_id != ID) || !r_last || (r_resp != 2'b00)) && (rerr_q != 2'b11)) begin
      rerr_d = 2'b10;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      b_ready_q    <= 1'b0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_write_q  <= 1'b0;
      first_beat_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      wstrb_q      <= '0;
      resp_q       <= '0;
      rerr_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q  <= 1'b0;
            addr_q       <= cmd_addr;
            wdata_q      <= cmd_wdata;
            wstrb_q      <= cmd_wstrb;
            rsp_write_q  <= cmd_write;
            rdata_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            rerr_q       <= '0;
            first_beat_q <= 1'b1;
            if (cmd_addr[1:0] != 2'b00) begin
              resp_q      <= 2'b10;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else if (cmd_write) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state_q    <= WADDR;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= RADDR;
            end
          end
        end
        WADDR: begin
          aw_done_q  <= aw_done_d;
          w_done_q   <= w_done_d;
          aw_valid_q <= aw_valid_q & ~aw_ready;
          w_valid_q  <= w_valid_q & ~w_ready;
          if (aw_done_d && w_done_d) begin
            b_ready_q <= 1'b1;
            state_q   <= WRESP;
          end
        end
        WRESP: begin
          if (b_valid) begin
            b_ready_q   <= 1'b0;
            resp_q      <= (b_id == ID) ? b_resp : 2'b10;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RADDR: begin
          if (ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= RDATA;
          end
        end
        RDATA: begin
          // Drain until r_last so a slave returning extra beats cannot wedge the channel.
          if (r_valid) begin
            first_beat_q <= 1'b0;
            rerr_q       <= rerr_d;
            if (first_beat_q) rdata_q <= r_data;
            if (r_last) begin
              r_ready_q   <= 1'b0;
              resp_q      <= rerr_d;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign aw_valid  = aw_valid_q;
  assign aw_id     = ID;
  assign aw_addr   = addr_q;
  assign aw_len    = 8'd0;
  assign aw_size   = 3'b010;
  assign aw_burst  = 2'b01;
  assign w_valid   = w_valid_q;
  assign w_data    = wdata_q;
  assign w_strb    = {4'b0000, wstrb_q};
  assign w_last    = 1'b1;
  assign b_ready   = b_ready_q;
  assign ar_valid  = ar_valid_q;
  assign ar_id     = ID;
  assign ar_addr   = addr_q;
  assign ar_len    = 8'd0;
  assign ar_size   = 3'b010;
  assign ar_burst  = 2'b01;
  assign r_ready   = r_ready_q;

endmodule

// File: tb/tb_axi4_mmio_master.sv
// Bench for axi4_mmio_master: directed timing cases, then random traffic against a memory-backed AXI slave.
module tb_axi4_mmio_master;
  localparam logic [3:0] ID = 4'h0;

  logic        clock = 1'b0;
  logic        resetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [30:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        aw_valid, aw_ready;
  logic [3:0]  aw_id;
  logic [30:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        w_valid, w_ready, w_last;
  logic [31:0] w_data;
  logic [7:0]  w_strb;
  logic        b_valid, b_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [30:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready, r_last;
  logic [3:0]  r_id;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  always #5 clock = ~clock;

  axi4_mmio_master #(.ID(ID)) dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last)
  );

  typedef struct {logic write; logic [31:0] rdata; logic [1:0] resp;} exp_t;
  typedef struct {logic [31:0] data; logic [1:0] resp; logic [3:0] id; logic last;} beat_t;

  exp_t        sb_q[$];
  beat_t       beat_q[$];
  logic [31:0] ref_mem[int];
  logic [31:0] slv_mem[int];
  int          n_checks = 0;
  int          n_errors = 0;
  int          rsp_mode = 0;  // 0: rsp_ready high, 1: random, 2: held low

  // Slave behaviour for the transaction in flight
  int          aw_stall, w_stall, ar_stall, b_delay, r_delay;
  logic [1:0]  s_bresp;
  logic [3:0]  s_bid;
  logic [30:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_wstrb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [30:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [30:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic [31:0] slv_rd(input logic [30:0] a);
    return slv_mem.exists(int'(a)) ? slv_mem[int'(a)] : init_val(a);
  endfunction

  // ---------------- AXI slave ----------------
  bit          got_aw, got_w, got_ar, b_fire, r_fire, committed;
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic [30:0] sw_addr;
  logic [31:0] sw_data;
  logic [3:0]  sw_strb;
  beat_t       bt;

  initial begin : slave
    aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
    b_id = 0; b_resp = 0; r_id = 0; r_data = 0; r_resp = 0; r_last = 0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        got_aw = 0; got_w = 0; got_ar = 0; b_fire = 0; r_fire = 0; committed = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_ready = 0; w_ready = 0; ar_ready = 0; b_valid = 0; r_valid = 0;
      end else begin
        if (b_fire) begin
          b_valid = 0; got_aw = 0; got_w = 0; committed = 0; b_cnt = 0; b_fire = 0;
        end
        if (got_aw && got_w && !b_valid) begin
          if (b_cnt >= b_delay) begin
            b_valid = 1; b_id = s_bid; b_resp = s_bresp;
          end else b_cnt++;
        end
        if (b_valid && b_ready) b_fire = 1;

        if (r_fire) begin
          void'(beat_q.pop_front());
          r_valid = 0; r_fire = 0;
        end
        if (got_ar) begin
          if (beat_q.size() == 0) got_ar = 0;
          else if (r_cnt >= r_delay) begin
            r_valid = 1; r_data = beat_q[0].data; r_resp = beat_q[0].resp;
            r_id = beat_q[0].id; r_last = beat_q[0].last;
          end else r_cnt++;
        end
        if (r_valid && r_ready) r_fire = 1;

        aw_ready = 0;
        if (aw_valid && !got_aw) begin
          chk("aw_addr", 64'(aw_addr), 64'(cur_addr));
          if (aw_cnt >= aw_stall) begin
            aw_ready = 1; got_aw = 1; aw_cnt = 0; sw_addr = aw_addr;
            chk("aw_fields", 64'({aw_id, aw_len, aw_size, aw_burst}), 64'({ID, 8'd0, 3'b010, 2'b01}));
          end else aw_cnt++;
        end
        w_ready = 0;
        if (w_valid && !got_w) begin
          chk("w_beat", 64'({w_data, w_strb, w_last}), 64'({cur_wdata, 4'h0, cur_wstrb, 1'b1}));
          if (w_cnt >= w_stall) begin
            w_ready = 1; got_w = 1; w_cnt = 0; sw_data = w_data; sw_strb = w_strb[3:0];
          end else w_cnt++;
        end
        if (got_aw && got_w && !committed) begin
          slv_mem[int'(sw_addr)] = merge(slv_rd(sw_addr), sw_data, sw_strb);
          committed = 1;
        end
        ar_ready = 0;
        if (ar_valid && !got_ar) begin
          chk("ar_addr", 64'(ar_addr), 64'(cur_addr));
          if (ar_cnt >= ar_stall) begin
            ar_ready = 1; got_ar = 1; ar_cnt = 0; r_cnt = 0;
            chk("ar_fields", 64'({ar_id, ar_len, ar_size, ar_burst}), 64'({ID, 8'd0, 3'b010, 2'b01}));
            if (beat_q.size() != 0) begin
              bt = beat_q[0]; bt.data = slv_rd(ar_addr); beat_q[0] = bt;
            end
          end else ar_cnt++;
        end
      end
    end
  end

  // ---------------- response monitor ----------------
  exp_t e_mon;
  initial begin : monitor
    rsp_ready = 0;
    forever begin
      @(negedge clock);
      rsp_ready = (rsp_mode == 0) ? 1'b1 : (rsp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (resetn && rsp_valid && rsp_ready) begin
        chk("rsp_expected", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          e_mon = sb_q.pop_front();
          chk("rsp_write", 64'(rsp_write), 64'(e_mon.write));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e_mon.rdata));
          chk("rsp_resp", 64'(rsp_resp), 64'(e_mon.resp));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle();
    int k = 0;
    while ((sb_q.size() != 0 || cmd_ready !== 1'b1) && k < 500) begin
      @(negedge clock);
      k++;
    end
    chk("idle_wait", 64'(k < 500), 64'd1);
  endtask

  task automatic set_script(input int aws, input int ws, input int ars, input int bd, input int rd,
                            input logic [1:0] bresp, input logic [3:0] bid);
    aw_stall = aws; w_stall = ws; ar_stall = ars; b_delay = bd; r_delay = rd;
    s_bresp = bresp; s_bid = bid;
  endtask

  task automatic add_beat(input logic [31:0] d, input logic [1:0] resp, input logic [3:0] id, input logic last);
    beat_t b;
    b.data = d; b.resp = resp; b.id = id; b.last = last;
    beat_q.push_back(b);
  endtask

  // Expected response is queued before the command goes out; returns at the negedge of cycle 1.
  task automatic issue(input logic wr, input logic [30:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    bit any3, anyerr;
    cur_addr = a; cur_wdata = d; cur_wstrb = s;
    e.write = wr;
    e.rdata = 32'h0;
    if (a[1:0] != 2'b00) begin
      e.resp = 2'b10;
    end else if (wr) begin
      e.resp = (s_bid == ID) ? s_bresp : 2'b10;
      ref_mem[int'(a)] = merge(ref_rd(a), d, s);
    end else begin
      e.rdata = ref_rd(a);
      any3 = 0; anyerr = 0;
      foreach (beat_q[i]) begin
        if (beat_q[i].resp == 2'b11) any3 = 1;
        if (beat_q[i].resp != 2'b00 || beat_q[i].id != ID || !beat_q[i].last) anyerr = 1;
      end
      e.resp = any3 ? 2'b11 : (anyerr ? 2'b10 : 2'b00);
    end
    sb_q.push_back(e);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clock);
    cmd_valid = 0;
  endtask

  task automatic chk_quiet(input string name);
    chk(name, 64'({cmd_ready, aw_valid, w_valid, b_ready, ar_valid, r_ready, rsp_valid}), 64'd0);
  endtask

  task automatic reset_pulse(input string name);
    int k;
    resetn = 0;
    sb_q.delete();
    @(negedge clock);
    chk_quiet(name);
    @(negedge clock);
    resetn = 1;
    @(negedge clock);
    chk({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    k = 0;
  endtask

  logic [30:0] a;
  logic        wr;
  int          nb, k;

  initial begin : stim
    resetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    set_script(0, 0, 0, 0, 0, 2'b00, ID);
    cur_addr = 0; cur_wdata = 0; cur_wstrb = 0;
    repeat (3) @(negedge clock);
    chk_quiet("reset_outputs");
    chk("reset_rsp", 64'({rsp_write, rsp_rdata, rsp_resp}), 64'd0);
    chk("const_fields", 64'({aw_len, aw_size, aw_burst, ar_len, ar_size, ar_burst, w_last}),
        64'({8'd0, 3'b010, 2'b01, 8'd0, 3'b010, 2'b01, 1'b1}));
    resetn = 1;
    @(negedge clock);
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    // Aligned write, minimum latency
    wait_idle();
    set_script(0, 0, 0, 0, 0, 2'b00, ID);
    issue(1, 31'h1000_0004, 32'hDEAD_BEEF, 4'hF);
    chk("wr_c1_valids", 64'({aw_valid, w_valid}), 64'b11);
    chk("wr_c1_aw_addr", 64'(aw_addr), 64'h1000_0004);
    chk("wr_c1_strb_last", 64'({w_strb, w_last}), 64'({8'h0F, 1'b1}));
    @(negedge clock);
    chk("wr_c2_bready", 64'({b_ready, rsp_valid}), 64'b10);
    @(negedge clock);
    chk("wr_c3_rsp_valid", 64'(rsp_valid), 64'd1);

    // Read with AR back-pressure
    wait_idle();
    issue(1, 31'h1000_0008, 32'h1234_5678, 4'hF);
    wait_idle();
    set_script(0, 0, 3, 0, 0, 2'b00, ID);
    add_beat(32'h0, 2'b00, ID, 1'b1);
    issue(0, 31'h1000_0008, 32'h0, 4'h0);
    for (int c = 1; c <= 4; c++) begin
      chk("rd_ar_hold", 64'({ar_valid, ar_addr}), 64'({1'b1, 31'h1000_0008}));
      @(negedge clock);
    end
    chk("rd_c5_rready", 64'({ar_valid, r_ready}), 64'b01);

    // Split write handshakes: W in cycle 1, AW in cycle 4
    wait_idle();
    set_script(3, 0, 0, 0, 0, 2'b00, ID);
    issue(1, 31'h1000_000C, 32'hCAFE_F00D, 4'h3);
    chk("split_c1", 64'({aw_valid, w_valid}), 64'b11);
    @(negedge clock);
    chk("split_c2_wdrop", 64'({aw_valid, w_valid}), 64'b10);
    @(negedge clock);
    @(negedge clock);
    chk("split_c4_bready", 64'({aw_valid, b_ready}), 64'b10);
    @(negedge clock);
    chk("split_c5_bready", 64'(b_ready), 64'd1);

    // Bad b_id
    wait_idle();
    set_script(0, 0, 0, 0, 0, 2'b00, 4'h3);
    issue(1, 31'h1000_0010, 32'h0BAD_1D00, 4'hF);

    // Two read beats, r_last only on the second
    wait_idle();
    set_script(0, 0, 0, 0, 0, 2'b00, ID);
    add_beat(32'h0, 2'b00, ID, 1'b0);
    add_beat(32'hFFFF_0000, 2'b00, ID, 1'b1);
    issue(0, 31'h1000_0004, 32'h0, 4'h0);
    @(negedge clock); @(negedge clock);
    @(negedge clock);
    chk("rd2_c4", 64'({rsp_valid, cmd_ready}), 64'b10);
    @(negedge clock);
    chk("rd2_c5_cmd_ready", 64'({rsp_valid, cmd_ready}), 64'b01);

    // Misaligned: no AXI traffic, immediate error response
    wait_idle();
    issue(1, 31'h1000_0002, 32'h1111_2222, 4'hF);
    chk("mis_c1_rsp_valid", 64'(rsp_valid), 64'd1);
    for (int c = 1; c <= 3; c++) begin
      chk("mis_no_axi", 64'({aw_valid, w_valid, ar_valid}), 64'd0);
      @(negedge clock);
    end

    // Reset while waiting in WRESP
    wait_idle();
    set_script(0, 0, 0, 1000, 0, 2'b00, ID);
    issue(1, 31'h1000_0014, 32'h5555_AAAA, 4'hF);
    k = 0;
    while (b_ready !== 1'b1 && k < 20) begin @(negedge clock); k++; end
    chk("wresp_reached", 64'(k < 20), 64'd1);
    reset_pulse("rst_wresp");

    // Reset while holding a response
    wait_idle();
    set_script(0, 0, 0, 0, 0, 2'b00, ID);
    rsp_mode = 2;
    add_beat(32'h0, 2'b00, ID, 1'b1);
    issue(0, 31'h1000_0014, 32'h0, 4'h0);
    k = 0;
    while (rsp_valid !== 1'b1 && k < 20) begin @(negedge clock); k++; end
    chk("resp_reached", 64'(k < 20), 64'd1);
    @(negedge clock);
    chk("resp_held", 64'(rsp_valid), 64'd1);
    reset_pulse("rst_resp");
    rsp_mode = 0;

    // Random traffic
    rsp_mode = 1;
    for (int i = 0; i < 60; i++) begin
      wait_idle();
      a  = 31'h1000_0000 + 31'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      wr = 1'($urandom_range(0, 1));
      set_script($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0) ? 4'h5 : ID);
      if (!wr && a[1:0] == 2'b00) begin
        nb = ($urandom_range(0, 4) == 0) ? 2 : 1;
        for (int j = 0; j < nb; j++)
          add_beat($urandom, ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                   ($urandom_range(0, 9) == 0) ? 4'h9 : ID, 1'(j == nb - 1));
      end
      issue(wr, a, $urandom, 4'($urandom_range(0, 15)));
    end
    wait_idle();
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4_mmio_master.md
# axi4_mmio_master

AXI4 initiator that turns a simple single-command request/response port into single-beat 32-bit AXI4 read and write transactions. It is the opposite end of the `io_axi4_0_*` MMIO port that the UART peripheral wrapper exposes as a responder. The bench or any local controller (debug bridge, boot loader) uses it to drive MMIO slaves. Exactly one transaction is outstanding at a time.

## Interface
- `ID`, default 4'h0: AXI ID driven on `aw_id` and `ar_id`, and the only ID accepted on B and R.
- `clock` input 1: sole clock, rising edge.
- `resetn` input 1: synchronous, active-low reset.
- `cmd_valid` input 1: command request.
- `cmd_ready` output 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_write` input 1: 1 = write, 0 = read.
- `cmd_addr` input 31: byte address.
- `cmd_wdata` input 32: write data.
- `cmd_wstrb` input 4: write byte enables.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: response consumed when `rsp_valid & rsp_ready`.
- `rsp_write` output 1: echo of `cmd_write`.
- `rsp_rdata` output 32: read data; 0 for writes.
- `rsp_resp` output 2: final response code.
- AXI AW channel: `aw_valid` out 1, `aw_ready` in 1, `aw_id` out 4, `aw_addr` out 31, `aw_len` out 8, `aw_size` out 3, `aw_burst` out 2.
- AXI W channel: `w_valid` out 1, `w_ready` in 1, `w_data` out 32, `w_strb` out 8, `w_last` out 1.
- AXI B channel: `b_valid` in 1, `b_ready` out 1, `b_id` in 4, `b_resp` in 2.
- AXI AR channel: `ar_valid` out 1, `ar_ready` in 1, `ar_id` out 4, `ar_addr` out 31, `ar_len` out 8, `ar_size` out 3, `ar_burst` out 2.
- AXI R channel: `r_valid` in 1, `r_ready` out 1, `r_id` in 4, `r_data` in 32, `r_resp` in 2, `r_last` in 1.

## Operation
- **Constant AXI fields:** `aw_len`/`ar_len` = 0, `aw_size`/`ar_size` = 3'b010, `aw_burst`/`ar_burst` = 2'b01, `w_last` = 1.
- **Write strobes:** `w_strb` = {4'b0, captured wstrb}.
- **States:** IDLE, WADDR, WRESP, RADDR, RDATA, RESP.
- **IDLE:**
  - `cmd_ready` = 1 only in IDLE.
  - On acceptance, address, data, strobe and write flag are registered.
  - If `cmd_addr[1:0]` != 0, go to RESP with `rsp_resp` = 2'b10 and `rsp_rdata` = 0. No AXI traffic is issued.
  - Otherwise a write goes to WADDR and a read goes to RADDR.
- **WADDR:**
  - `aw_valid` and `w_valid` rise together. Each is held with stable payload until its own handshake.
  - Sticky flags `aw_done` and `w_done` record each handshake; the two handshakes may complete in either order or in the same cycle.
  - When both flags are set, go to WRESP.
- **WRESP:**
  - `b_ready` = 1.
  - On the `b_valid` handshake, go to RESP with `rsp_resp` = `b_resp` if `b_id` == ID, else 2'b10.
- **RADDR:** `ar_valid` = 1 until `ar_ready`, then go to RDATA.
- **RDATA:**
  - `r_ready` = 1.
  - The first beat's `r_data` is captured into `rsp_rdata`.
  - An error is latched if `r_id` != ID, if `r_last` = 0, or if any beat carries `r_resp` != 0. The latched error is SLVERR 2'b10, unless a beat's `r_resp` was 2'b11; 2'b11 has priority.
  - Beats keep being accepted until a beat with `r_last` = 1 arrives, so a misbehaving slave cannot hang the bus. Then go to RESP.
- **RESP:** `rsp_valid` = 1 with stable `rsp_*` until `rsp_ready`, then go to IDLE.
- **Reset values:** state IDLE; every `*_valid` and `*_ready` output 0; `rsp_*` 0; address and data registers 0. The constant AXI fields are unaffected by reset.
- **Reset mid-transaction:** the transaction is abandoned. The connected slave is required to be reset by the same `resetn`.

## Timing
- All outputs are registered or decoded from the state register; there is no combinational path from AXI inputs to AXI outputs.
- **Write minimum latency:**
  - Cycle 0: command accepted.
  - Cycle 1: `aw_valid`/`w_valid` high; both handshakes complete if ready is high.
  - Cycle 2: `b_ready` high; `b_valid` is accepted here.
  - Cycle 3: `rsp_valid`.
- **Read minimum latency:** cycle 1 `ar_valid`, cycle 2 `r_ready` and beat, cycle 3 `rsp_valid`.
- **Misaligned command:** `rsp_valid` in cycle 1.
- **Throughput:** the next `cmd_ready` is in the cycle after the `rsp` handshake. `rsp_ready` held high therefore gives back-to-back commands every 4 cycles minimum.
- **Back-pressure:** an AXI ready held low N cycles extends the matching state by N cycles; valid and payload do not change while waiting.

## Test plan
- **Aligned write:** write addr 0x1000_0004, data 0xDEADBEEF, strb 4'hF, all slave readies high.
  - `aw_addr` = 0x1000_0004, `w_strb` = 8'h0F, `w_last` = 1 in cycle 1.
  - `rsp_valid` in cycle 3 with `rsp_resp` 0.
- **Read with back-pressure:** read 0x1000_0008 with `ar_ready` low for 3 cycles.
  - `ar_valid` and `ar_addr` are stable for 4 cycles.
  - `r_data` 0x12345678 yields `rsp_rdata` 0x12345678 and `rsp_resp` 0.
- **Split write handshakes:** `w_ready` high in cycle 1, `aw_ready` only in cycle 4.
  - `w_valid` drops after cycle 1.
  - `b_ready` is first high in cycle 5.
- **Error paths, one sub-case each:**
  - `b_id` 4'h3 with ID 0 → `rsp_resp` 2'b10.
  - Read returning 2 beats with `r_last` only on the second → `rsp_rdata` = first beat, `rsp_resp` 2'b10, `cmd_ready` returns afterwards.
- **Misaligned command:** addr 0x1000_0002 → no AXI valid ever asserted; `rsp_valid` in cycle 1 with `rsp_resp` 2'b10.
- **Reset mid-transaction:** `resetn` low while in WRESP and while in RESP with `rsp_ready` low.
  - The next cycle shows all valid/ready outputs 0 and `cmd_ready` 0.
  - The cycle after `resetn` rises shows `cmd_ready` 1.
